// File: rtl/fft_stream_ctrl.sv
// ============================================================================
// fft_stream_ctrl : stream front/back end for the fft core (load, start,
//                   capture burst, replay), with IFFT conjugation and checks.
// Revision 1.0
// ============================================================================
`default_nettype none

module fft_stream_ctrl #(
  parameter int width      = 16,
  parameter int N_2        = 5,
  parameter int BITREV_OUT = 0,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*width-1:0] s_data,
  input  logic               s_last,
  input  logic               s_inv,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*width-1:0] m_data,
  output logic               m_last,
  output logic               fft_load,
  output logic               fft_start,
  output logic [N_2-1:0]     fft_adr,
  output logic [2*width-1:0] fft_rd,
  input  logic [2*width-1:0] fft_wd,
  input  logic               fft_done,
  output logic               frame_err,
  output logic               timeout_err,
  output logic               busy
);

  localparam int N   = 1 << N_2;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [N_2:0] LAST = (N_2+1)'(N - 1);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [N_2:0]       in_cnt, in_cnt_nx;
  logic [N_2:0]       out_cnt, out_cnt_nx;
  logic [N_2:0]       rd_idx, rd_idx_nx;
  logic [WCW-1:0]     wait_cnt, wait_cnt_nx;
  logic               inv_q, inv_q_nx;
  logic               inv_cur;
  logic               wr_en;
  logic [N_2-1:0]     wr_idx;
  logic               md_ld;
  logic [2*width-1:0] mem [N];
  logic [2*width-1:0] m_data_q;

  // Negate the imaginary part; the most negative value saturates.
  function automatic logic [2*width-1:0] conj(input logic [2*width-1:0] x);
    logic [width-1:0] im;
    im = x[width-1:0];
    if (im == {1'b1, {(width-1){1'b0}}})
      im = {1'b0, {(width-1){1'b1}}};
    else
      im = -im;
    return {x[2*width-1:width], im};
  endfunction

  function automatic logic [N_2-1:0] cap_idx(input logic [N_2-1:0] j);
    logic [N_2-1:0] r;
    for (int b = 0; b < N_2; b++) r[b] = j[N_2-1-b];
    return (BITREV_OUT != 0) ? r : j;
  endfunction

  // Beat 0 decides the frame mode before inv_q has latched it.
  assign inv_cur = (in_cnt == '0) ? s_inv : inv_q;

  always_comb begin
    state_nx    = state;
    in_cnt_nx   = in_cnt;
    out_cnt_nx  = out_cnt;
    rd_idx_nx   = rd_idx;
    wait_cnt_nx = wait_cnt;
    inv_q_nx    = inv_q;
    fft_load    = 1'b0;
    fft_adr     = '0;
    fft_rd      = '0;
    fft_start   = 1'b0;
    frame_err   = 1'b0;
    timeout_err = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    md_ld       = 1'b0;
    case (state)
      LOAD: begin
        if (s_valid) begin
          fft_load = 1'b1;
          fft_adr  = in_cnt[N_2-1:0];
          fft_rd   = inv_cur ? conj(s_data) : s_data;
          if (in_cnt == '0) inv_q_nx = s_inv;
          if (in_cnt == LAST) begin
            frame_err = ~s_last;
            in_cnt_nx = '0;
            state_nx  = START;
          end else if (s_last) begin
            frame_err = 1'b1;
            in_cnt_nx = '0;
          end else begin
            in_cnt_nx = in_cnt + (N_2+1)'(1);
          end
        end
      end
      START: begin
        fft_start   = 1'b1;
        wait_cnt_nx = '0;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          wr_en      = 1'b1;
          wr_idx     = cap_idx('0);
          out_cnt_nx = (N_2+1)'(1);
          state_nx   = CAPTURE;
        end else if (wait_cnt == WCW'(TIMEOUT)) begin
          timeout_err = 1'b1;
          state_nx    = LOAD;
        end else begin
          wait_cnt_nx = wait_cnt + WCW'(1);
        end
      end
      CAPTURE: begin
        if (fft_done) begin
          wr_en  = 1'b1;
          wr_idx = cap_idx(out_cnt[N_2-1:0]);
          if (out_cnt == LAST) begin
            out_cnt_nx = '0;
            rd_idx_nx  = '0;
            md_ld      = 1'b1;
            state_nx   = DRAIN;
          end else begin
            out_cnt_nx = out_cnt + (N_2+1)'(1);
          end
        end else begin
          timeout_err = 1'b1;
          out_cnt_nx  = '0;
          state_nx    = LOAD;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (rd_idx == LAST) begin
            rd_idx_nx = '0;
            state_nx  = LOAD;
          end else begin
            rd_idx_nx = rd_idx + (N_2+1)'(1);
            md_ld     = 1'b1;
          end
        end
      end
      default: state_nx = LOAD;
    endcase
    // Outputs stay quiet while reset is held.
    if (!reset) begin
      fft_load    = 1'b0;
      fft_adr     = '0;
      fft_rd      = '0;
      fft_start   = 1'b0;
      frame_err   = 1'b0;
      timeout_err = 1'b0;
      wr_en       = 1'b0;
      md_ld       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LOAD;
      in_cnt   <= '0;
      out_cnt  <= '0;
      rd_idx   <= '0;
      wait_cnt <= '0;
      inv_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      in_cnt   <= in_cnt_nx;
      out_cnt  <= out_cnt_nx;
      rd_idx   <= rd_idx_nx;
      wait_cnt <= wait_cnt_nx;
      inv_q    <= inv_q_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= fft_wd;
  end

  // Prefetch the word for the next rd_idx so m_data is registered.
  always_ff @(posedge clk) begin
    if (!reset)
      m_data_q <= '0;
    else if (md_ld)
      m_data_q <= inv_q ? conj(mem[rd_idx_nx[N_2-1:0]]) : mem[rd_idx_nx[N_2-1:0]];
  end

  assign s_ready = ~reset | (state == LOAD);
  assign m_valid = reset & (state == DRAIN);
  assign m_last  = m_valid & (rd_idx == LAST);
  assign m_data  = m_data_q;
  assign busy    = reset & ((state != LOAD) | (in_cnt != '0));

endmodule

`default_nettype wire

// File: tb/tb_fft_stream_ctrl.sv
// ============================================================================
// tb_fft_stream_ctrl : randomized check of fft_stream_ctrl against a frame model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fft_stream_ctrl;

  localparam int W = 16, N_2 = 5, N = 32, TMO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid, s_last, s_inv, m_ready, fft_done;
  logic [31:0]   s_data, fft_wd;
  logic          s_ready, m_valid, m_last, fft_load, fft_start, frame_err, timeout_err, busy;
  logic [31:0]   m_data, fft_rd;
  logic [N_2-1:0] fft_adr;
  logic          s_ready_b, m_valid_b, m_last_b, fft_load_b, fft_start_b, frame_err_b, timeout_err_b, busy_b;
  logic [31:0]   m_data_b, fft_rd_b;
  logic [N_2-1:0] fft_adr_b;

  fft_stream_ctrl #(.width(W), .N_2(N_2), .BITREV_OUT(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_inv(s_inv), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .fft_load(fft_load), .fft_start(fft_start), .fft_adr(fft_adr),
    .fft_rd(fft_rd), .fft_wd(fft_wd), .fft_done(fft_done), .frame_err(frame_err),
    .timeout_err(timeout_err), .busy(busy));

  fft_stream_ctrl #(.width(W), .N_2(N_2), .BITREV_OUT(1), .TIMEOUT(TMO)) dut_br (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .s_last(s_last), .s_inv(s_inv), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_last(m_last_b), .fft_load(fft_load_b), .fft_start(fft_start_b), .fft_adr(fft_adr_b),
    .fft_rd(fft_rd_b), .fft_wd(fft_wd), .fft_done(fft_done), .frame_err(frame_err_b),
    .timeout_err(timeout_err_b), .busy(busy_b));

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] conj_if(input bit inv, input logic [31:0] x);
    int v;
    if (!inv) return x;
    v = $signed(x[15:0]);
    v = -v;
    if (v > 32767) v = 32767;
    return {x[31:16], v[15:0]};
  endfunction

  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < N_2; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  // Core stub transform: output word j derived from loaded word j.
  function automatic logic [31:0] core_fn(input logic [31:0] x, input int j);
    logic [15:0] re;
    re = x[31:16] + 16'(3 * j);
    return {re, x[15:0] ^ 16'(j)};
  endfunction

  logic [31:0] fr [N];
  logic [31:0] mdl_ld [N];
  logic [31:0] core_mem [N];
  logic [31:0] exp_q[$], exp_qb[$];
  int cur_k = 0;
  int n_ferr = 0, n_start = 0, n_tmo = 0;
  int exp_ferr = 0, exp_start = 0, exp_tmo = 0;
  bit no_done = 1'b0;
  int rmode = 0;

  // Load-side observation: what the core receives.
  always @(negedge clk) begin
    if (fft_load) begin
      core_mem[fft_adr] = fft_rd;
      check("fft_adr", fft_adr, cur_k[N_2-1:0]);
      check("fft_rd", fft_rd, mdl_ld[cur_k]);
      check("busy_load", busy, cur_k != 0);
    end
    if (frame_err) n_ferr++;
    if (fft_start) n_start++;
    if (timeout_err) n_tmo++;
  end

  // Core stub: after start, random latency, then N words with done high.
  initial begin
    fft_done = 1'b0;
    fft_wd   = '0;
    forever begin
      @(negedge clk);
      if (fft_start && !no_done) begin : burst
        int d;
        d = $urandom_range(0, 5);
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        for (int j = 0; j < N; j++) begin
          fft_done = 1'b1;
          fft_wd   = core_fn(core_mem[j], j);
          @(posedge clk); #1;
        end
        fft_done = 1'b0;
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor for both instances.
  int opos = 0, oposb = 0;
  bit stall = 1'b0, last_hs = 1'b0;
  logic [31:0] held, e;
  always @(negedge clk) begin
    if (last_hs) begin
      check("s_ready_after_drain", s_ready, 1);
      last_hs = 1'b0;
    end
    if (stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, held);
      stall = 1'b0;
    end
    if (m_valid) begin
      if (m_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", m_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e);
          check("m_last", m_last, opos == N - 1);
          opos = (opos + 1) % N;
          if (m_last) last_hs = 1'b1;
        end
      end else begin
        stall = 1'b1;
        held  = m_data;
      end
    end
    if (m_valid_b && m_ready) begin
      if (exp_qb.size() == 0) check("unexpected_out_br", m_valid_b, 0);
      else begin
        e = exp_qb.pop_front();
        check("m_data_br", m_data_b, e);
        check("m_last_br", m_last_b, oposb == N - 1);
        oposb = (oposb + 1) % N;
      end
    end
  end

  task automatic send_frame(input int len, input bit inv, input bit put_last);
    int t, r;
    for (int k = 0; k < N; k++) mdl_ld[k] = conj_if(inv, fr[k]);
    if (len < N || !put_last) exp_ferr++;
    if (len == N) begin
      exp_start++;
      if (no_done) exp_tmo++;
      else
        for (int i = 0; i < N; i++) begin
          exp_q.push_back(conj_if(inv, core_fn(mdl_ld[i], i)));
          r = rev(i);
          exp_qb.push_back(conj_if(inv, core_fn(mdl_ld[r], r)));
        end
    end
    @(posedge clk); #1;
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(0, 2)) begin s_valid = 1'b0; @(posedge clk); #1; end
      cur_k   = k;
      s_valid = 1'b1;
      s_data  = fr[k];
      s_last  = (k == len - 1) && put_last;
      s_inv   = (k == 0) ? inv : 1'($urandom_range(0, 1));
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) check("s_ready_wait", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() > 0 || exp_qb.size() > 0) && t < 3000) begin @(negedge clk); t++; end
    check("drain_done", exp_q.size() + exp_qb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) fr[k] = $urandom;
  endtask

  initial begin : main
    int t;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; s_last = 1'b0; s_inv = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_fft_load", fft_load, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset   = 1'b1;

    // impulse FFT frame
    for (int k = 0; k < N; k++) fr[k] = 32'h0;
    fr[0] = 32'h4000_0000;
    send_frame(N, 1'b0, 1'b1);
    wait_drain();
    check("busy_idle", busy, 0);

    // IFFT frame with saturation corner cases
    rand_frame();
    fr[0][15:0] = 16'h8000;
    fr[1][15:0] = 16'h7FFF;
    fr[5][15:0] = 16'h0000;
    send_frame(N, 1'b1, 1'b1);
    wait_drain();

    // short frame discarded, then a normal one
    begin : short_frame
      int f0, s0;
      f0 = n_ferr; s0 = n_start;
      rand_frame();
      send_frame(11, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("short_ferr", n_ferr, f0 + 1);
      check("short_nostart", n_start, s0);
      check("short_busy", busy, 0);
    end
    rand_frame();
    send_frame(N, 1'b0, 1'b1);
    wait_drain();

    // done never arrives
    no_done = 1'b1;
    rand_frame();
    send_frame(N, 1'b0, 1'b1);
    t = 0;
    @(negedge clk);
    while (!fft_start && t < 50) begin @(negedge clk); t++; end
    t = 0;
    do begin @(negedge clk); t++; end while (!timeout_err && t < 200);
    check("timeout_cycle", t, TMO + 1);
    @(negedge clk);
    check("s_ready_after_tmo", s_ready, 1);
    check("m_valid_after_tmo", m_valid, 0);
    no_done = 1'b0;

    // stalled drain with toggling ready
    rmode = 1;
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      send_frame(N, 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    // random ready, random missing s_last on beat N-1
    rmode = 2;
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(N, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_drain();
    end
    rmode = 0;

    // reset while waiting for the core
    no_done = 1'b1;
    rand_frame();
    send_frame(N, 1'b0, 1'b1);
    exp_tmo--;
    repeat (5) @(negedge clk);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("rst_mid_s_ready", s_ready, 1);
    check("rst_mid_busy", busy, 0);
    repeat (TMO + 20) @(negedge clk);
    no_done = 1'b0;

    check("frame_err_total", n_ferr, exp_ferr);
    check("start_total", n_start, exp_start);
    check("timeout_total", n_tmo, exp_tmo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
